// File: rtl/proc_pkt_arbiter_if.sv
// Requester-side packet bundle for the GLB proc port arbiter.
// Two requesters share each signal; requester i owns slice/bit i.
interface proc_pkt_arbiter_if #(
  parameter int BANK_DATA_WIDTH = 64,
  parameter int GLB_ADDR_WIDTH  = 22
);
  logic [1:0]                     req_valid;
  logic [1:0]                     req_ready;
  logic [1:0]                     req_wr;
  logic [2*BANK_DATA_WIDTH/8-1:0] req_strb;
  logic [2*GLB_ADDR_WIDTH-1:0]    req_addr;
  logic [2*BANK_DATA_WIDTH-1:0]   req_data;
  logic [1:0]                     rsp_valid;
  logic [BANK_DATA_WIDTH-1:0]     rsp_data;

  modport master (
    output req_valid, req_wr, req_strb,
    output req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_strb,
    input  req_addr, req_data,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/proc_pkt_arbiter.sv
// Round-robin sharing of the GLB proc port between two requesters.
// Read returns are routed back through an in-order tag FIFO.
module proc_pkt_arbiter #(
  parameter int BANK_DATA_WIDTH = 64,
  parameter int GLB_ADDR_WIDTH  = 22,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst_n,
  proc_pkt_arbiter_if.slave req_if,
  output logic                         wr_en,
  output logic [BANK_DATA_WIDTH/8-1:0] wr_strb,
  output logic [GLB_ADDR_WIDTH-1:0]    wr_addr,
  output logic [BANK_DATA_WIDTH-1:0]   wr_data,
  output logic                         rd_en,
  output logic [GLB_ADDR_WIDTH-1:0]    rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0]   rd_data,
  input  logic                         rd_data_valid,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                         err_spurious
);
  localparam int SW = BANK_DATA_WIDTH / 8;
  localparam int AW = GLB_ADDR_WIDTH;
  localparam int DW = BANK_DATA_WIDTH;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);

  logic                       prio_q;
  logic [PW-1:0]              wptr_q;
  logic [PW-1:0]              rptr_q;
  logic [CW-1:0]              cnt_q;
  logic [MAX_OUTSTANDING-1:0] tag_q;

  logic          tag_full;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          sel;
  logic          any;
  logic          g_wr;
  logic [SW-1:0] g_strb;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  logic          push;
  logic          pop;

  assign tag_full = (cnt_q == FULL);

  // Eligibility and grant: rotate on contention, else serve the lone one
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_if.req_valid[i]
              && (req_if.req_wr[i] || !tag_full);
    end
    if (elig == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
  end

  assign req_if.req_ready = rst_n ? grant : 2'b00;

  assign sel = grant[1];
  assign any = |grant;

  assign g_wr   = req_if.req_wr[sel];
  assign g_strb = sel ? req_if.req_strb[SW +: SW]
                      : req_if.req_strb[0 +: SW];
  assign g_addr = sel ? req_if.req_addr[AW +: AW]
                      : req_if.req_addr[0 +: AW];
  assign g_data = sel ? req_if.req_data[DW +: DW]
                      : req_if.req_data[0 +: DW];

  assign push = any && !g_wr;
  assign pop  = rd_data_valid && (cnt_q != '0);

  // Round-robin pointer hands priority to the other side after a grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (any) begin
      prio_q <= ~sel;
    end
  end

  // Registered single-beat GLB packet, fields zeroed when unused
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_strb <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      wr_en   <= any && g_wr;
      wr_strb <= (any && g_wr) ? g_strb : '0;
      wr_addr <= (any && g_wr) ? g_addr : '0;
      wr_data <= (any && g_wr) ? g_data : '0;
      rd_en   <= push;
      rd_addr <= push ? g_addr : '0;
    end
  end

  // In-order tag FIFO holding the requester id of each read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wptr_q] <= sel;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Return path: route popped data to its owner, flag orphan returns
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_if.rsp_valid <= 2'b00;
      req_if.rsp_data  <= '0;
      err_spurious     <= 1'b0;
    end else begin
      req_if.rsp_valid <= pop ? (tag_q[rptr_q] ? 2'b10 : 2'b01)
                              : 2'b00;
      req_if.rsp_data  <= pop ? rd_data : '0;
      if (rd_data_valid && (cnt_q == '0)) begin
        err_spurious <= 1'b1;
      end
    end
  end

  assign outstanding = cnt_q;

endmodule

// File: doc/proc_pkt_arbiter.md
# proc_pkt_arbiter

Shares the GLB processor port (write/read packet interface) between two requesters: requester 0 is the host/AXI bridge, requester 1 is the test/DMA loader. It accepts one packet per cycle under round-robin arbitration, drives a registered single-beat packet onto the GLB proc port, and returns read data to the requester that issued each read. Read ordering is tracked with an in-order tag FIFO.

## Interface
- BANK_DATA_WIDTH, 64, data width of one proc beat
- GLB_ADDR_WIDTH, 22, GLB byte address width
- MAX_OUTSTANDING, 4, max in-flight reads; power of two, ≥2
- clk  in  1  clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- req_valid  in  2  per-requester packet valid (bit i = requester i)
- req_ready  out  2  per-requester accept; packet transfers when valid&ready
- req_wr  in  2  1 = write packet, 0 = read packet
- req_strb  in  2*BANK_DATA_WIDTH/8  byte strobes, requester i at slice i
- req_addr  in  2*GLB_ADDR_WIDTH  addresses, slice i
- req_data  in  2*BANK_DATA_WIDTH  write data, slice i
- rsp_valid  out  2  read data valid for requester i
- rsp_data  out  BANK_DATA_WIDTH  read data, shared by both requesters
- wr_en, wr_strb, wr_addr, wr_data  out  1/BANK_DATA_WIDTH/8/GLB_ADDR_WIDTH/BANK_DATA_WIDTH  GLB write packet
- rd_en, rd_addr  out  1/GLB_ADDR_WIDTH  GLB read packet
- rd_data, rd_data_valid  in  BANK_DATA_WIDTH/1  GLB read return
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
- err_spurious  out  1  sticky: rd_data_valid seen with empty tag FIFO

## Operation
- Eligibility: requester i is eligible if req_valid[i] && (req_wr[i] || !tag_full).
- Arbitration: round-robin pointer `prio` (reset 0). If both are eligible, grant `prio`. Otherwise grant the single eligible requester. At most one grant per cycle.
- After any grant, `prio` becomes the other requester. With no grant, `prio` holds.
- req_ready[i] = grant[i]. It is combinational from req_valid, req_wr and registered state. Never assert ready to an ineligible requester.
- Accepted write: the next cycle, wr_en=1 with the registered strb/addr/data, and rd_en=0.
- Accepted read: the next cycle, rd_en=1 with rd_addr, wr_en=0, wr_strb/wr_data=0. The requester id is pushed into the tag FIFO in the accept cycle.
- wr_en and rd_en are never both 1. Each is a one-cycle pulse per accepted packet.
- Return: on rd_data_valid with a non-empty FIFO, pop the head id h. The next cycle, rsp_valid[h]=1 and rsp_data=rd_data.
- Return on an empty FIFO: data is dropped, err_spurious is set (cleared only by reset), and rsp_valid stays 0.
- tag_full: count == MAX_OUTSTANDING, using the registered count. A pop in the same cycle does NOT unblock a read grant.
- Simultaneous push and pop: count unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.
- outstanding = registered count.

## Timing
- Reset (rst_n=0 at a clk edge) clears all outputs to 0: wr_en, rd_en, wr_*, rd_addr, rsp_valid, rsp_data, outstanding, err_spurious. It also sets prio=0 and empties the FIFO. req_ready is 0 while rst_n=0.
- Reset mid-operation discards in-flight tags. Read returns arriving after reset are spurious and set err_spurious.
- Request latency: accept at cycle t, GLB packet at t+1. Throughput is 1 packet/cycle.
- Response latency: rd_data_valid at cycle r gives rsp_valid at r+1. Back-to-back returns give back-to-back rsp_valid.
- Requesters hold valid and payload stable until accepted. Requesters have no back-pressure on responses.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=2'b11 -> all outputs 0, req_ready=0. After release, first grant goes to requester 0.
- Round-robin writes: both valid continuously, writes to addr 0x100 (req0) and 0x200 (req1) -> wr_addr sequence 0x100,0x200,0x100,0x200 on consecutive cycles, wr_en held 1, rd_en 0.
- Read routing: req1 reads 0x40, then req0 reads 0x80. Model returns 0xAAAA then 0xBBBB at 3-cycle latency -> rsp_valid=2'b10 with 0xAAAA, then rsp_valid=2'b01 with 0xBBBB, each one cycle after its rd_data_valid. outstanding goes 1,2,1,0.
- Full: MAX_OUTSTANDING=4, issue 4 reads with no return -> outstanding=4, read req_ready=0. A concurrent write is still accepted. In the pop cycle the read is still blocked; it is granted the next cycle.
- Spurious: rd_data_valid=1 with outstanding=0 -> err_spurious=1 and stays 1, rsp_valid=0. Assert rst_n=0 -> err_spurious=0.
- Reset mid-flight: 2 reads outstanding, pulse reset, then 2 returns -> no rsp_valid, err_spurious=1, outstanding=0.
